// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined immediate generator for the ID stage.
// Decodes opcode plus three FIELD_W-bit instruction fields into a DATA_W-bit
// immediate and registers it behind a valid/ready handshake (1-cycle latency).
// Optional macro IMM_PREFIX_EN adds a prefix opcode (4'b1111) whose fields
// supply the upper immediate bits of the next MEM/ALU/BRANCH instruction.
// DATA_W must be at least 3*FIELD_W.
module imm_gen_pipe #(
    parameter int DATA_W  = 16,
    parameter int FIELD_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         opcode,
    input  logic [FIELD_W-1:0] f1,
    input  logic [FIELD_W-1:0] f2,
    input  logic [FIELD_W-1:0] f3,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_imm,
    output logic [2:0]         out_kind,
    output logic               out_prefixed
);

    localparam logic [3:0] OP_MEM    = 4'b1000;
    localparam logic [3:0] OP_ALU    = 4'b0101;
    localparam logic [3:0] OP_BRANCH = 4'b1100;
    localparam logic [3:0] OP_UPPER  = 4'b1101;
    localparam logic [3:0] OP_PFX    = 4'b1111;

    localparam logic [2:0] KIND_NONE   = 3'd0;
    localparam logic [2:0] KIND_MEM    = 3'd1;
    localparam logic [2:0] KIND_ALU    = 3'd2;
    localparam logic [2:0] KIND_BRANCH = 3'd3;
    localparam logic [2:0] KIND_UPPER  = 3'd4;

    // Width of the prefix register: everything above the f3 field.
    localparam int PFX_W = DATA_W - FIELD_W;

    logic              accept;
    logic [DATA_W-1:0] sx1;
    logic [DATA_W-1:0] sx2;
    logic [DATA_W-1:0] sx3;
    logic [DATA_W-1:0] upper_imm;
    logic [DATA_W-1:0] dec_imm;
    logic [2:0]        dec_kind;
    logic              dec_is_pfx;
    logic [DATA_W-1:0] res_imm;
    logic              res_prefixed;

    // A new instruction is taken when the output slot is free or retiring.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready && !flush;

    // Sign-extended field concatenations (1, 2 and 3 fields wide).
    always_comb begin
        sx1 = {DATA_W{f3[FIELD_W-1]}};
        sx1[FIELD_W-1:0] = f3;
        sx2 = {DATA_W{f2[FIELD_W-1]}};
        sx2[2*FIELD_W-1:0] = {f2, f3};
        sx3 = {DATA_W{f1[FIELD_W-1]}};
        sx3[3*FIELD_W-1:0] = {f1, f2, f3};
        upper_imm = '0;
        upper_imm[DATA_W-1 -: 2*FIELD_W] = {f2, f3};
    end

    // Plain (unprefixed) opcode decode.
    always_comb begin
        dec_imm    = '0;
        dec_kind   = KIND_NONE;
        dec_is_pfx = 1'b0;
        case (opcode)
            OP_MEM: begin
                dec_imm  = sx1;
                dec_kind = KIND_MEM;
            end
            OP_ALU: begin
                dec_imm  = sx2;
                dec_kind = KIND_ALU;
            end
            OP_BRANCH: begin
                dec_imm  = sx3;
                dec_kind = KIND_BRANCH;
            end
            OP_UPPER: begin
                dec_imm  = upper_imm;
                dec_kind = KIND_UPPER;
            end
`ifdef IMM_PREFIX_EN
            OP_PFX: begin
                dec_is_pfx = 1'b1;
            end
`endif
            default: begin
                dec_imm  = '0;
                dec_kind = KIND_NONE;
            end
        endcase
    end

`ifdef IMM_PREFIX_EN
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ARMED = 1'b1;

    logic [0:0]       state;
    logic [PFX_W-1:0] pfx_reg;
    logic             pfx_applies;

    // Only MEM/ALU/BRANCH consume a pending prefix; UPPER and NONE discard it.
    assign pfx_applies = (state == ST_ARMED) &&
                         ((dec_kind == KIND_MEM) || (dec_kind == KIND_ALU) ||
                          (dec_kind == KIND_BRANCH));

    // Result selection: prefix bits replace everything above f3.
    always_comb begin
        res_imm      = dec_imm;
        res_prefixed = 1'b0;
        if (pfx_applies) begin
            res_imm      = {pfx_reg, f3};
            res_prefixed = 1'b1;
        end
    end

    // Prefix state machine: any accepted non-PFX instruction returns to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            pfx_reg <= '0;
        end else if (flush) begin
            state <= ST_IDLE;
        end else if (accept) begin
            if (dec_is_pfx) begin
                state   <= ST_ARMED;
                pfx_reg <= sx3[PFX_W-1:0];
            end else begin
                state <= ST_IDLE;
            end
        end
    end
`else
    // Without prefix support the decode result passes straight through.
    always_comb begin
        res_imm      = dec_imm;
        res_prefixed = 1'b0;
    end
`endif

    // Output register: flush drops everything, PFX leaves a bubble,
    // a held result (out_valid && !out_ready) is not touched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_imm      <= '0;
            out_kind     <= KIND_NONE;
            out_prefixed <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            if (dec_is_pfx) begin
                out_valid <= 1'b0;
            end else begin
                out_valid    <= 1'b1;
                out_imm      <= res_imm;
                out_kind     <= dec_kind;
                out_prefixed <= res_prefixed;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed, table-driven bench for imm_gen_pipe (DATA_W=16, FIELD_W=4).
// Prefix sequences run only when IMM_PREFIX_EN is defined.
module tb_imm_gen_pipe;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  opcode;
    logic [3:0]  f1, f2, f3;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_imm;
    logic [2:0]  out_kind;
    logic        out_prefixed;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  op;
        logic [3:0]  a;
        logic [3:0]  b;
        logic [3:0]  c;
        logic [15:0] imm;
        logic [2:0]  kind;
    } vec_t;

    vec_t vecs[$];

    imm_gen_pipe #(.DATA_W(16), .FIELD_W(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .opcode       (opcode),
        .f1           (f1),
        .f2           (f2),
        .f3           (f3),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_imm      (out_imm),
        .out_kind     (out_kind),
        .out_prefixed (out_prefixed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] op,
                         input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
        in_valid = v;
        opcode   = op;
        f1       = a;
        f2       = b;
        f3       = c;
    endtask

    task automatic expect_out(input string name, input logic [15:0] imm,
                              input logic [2:0] kind, input logic pfx);
        check({name, ".valid"}, 32'(out_valid), 32'd1);
        check({name, ".imm"}, 32'(out_imm), 32'(imm));
        check({name, ".kind"}, 32'(out_kind), 32'(kind));
        check({name, ".pfx"}, 32'(out_prefixed), 32'(pfx));
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 4'h0, 4'h0, 4'h0, 4'h0);

        vecs.push_back('{4'b1000, 4'h0, 4'h0, 4'h3, 16'h0003, 3'd1});
        vecs.push_back('{4'b1000, 4'h0, 4'h0, 4'hA, 16'hFFFA, 3'd1});
        vecs.push_back('{4'b0101, 4'h0, 4'h2, 4'h3, 16'h0023, 3'd2});
        vecs.push_back('{4'b1100, 4'h8, 4'h2, 4'h3, 16'hF823, 3'd3});
        vecs.push_back('{4'b1101, 4'h6, 4'hA, 4'h5, 16'hA500, 3'd4});
        vecs.push_back('{4'b0000, 4'h7, 4'h7, 4'h7, 16'h0000, 3'd0});
        vecs.push_back('{4'b0101, 4'hC, 4'h8, 4'h0, 16'hFF80, 3'd2});
        vecs.push_back('{4'b1100, 4'h7, 4'hF, 4'hF, 16'h07FF, 3'd3});
        vecs.push_back('{4'b1001, 4'hF, 4'hF, 4'hF, 16'h0000, 3'd0});
        vecs.push_back('{4'b1000, 4'h9, 4'h9, 4'h7, 16'h0007, 3'd1});
        vecs.push_back('{4'b1000, 4'h1, 4'h1, 4'h8, 16'hFFF8, 3'd1});
        vecs.push_back('{4'b0101, 4'h0, 4'h7, 4'hF, 16'h007F, 3'd2});
`ifndef IMM_PREFIX_EN
        vecs.push_back('{4'b1111, 4'h1, 4'h2, 4'h3, 16'h0000, 3'd0});
`endif

        // Reset state
        #12;
        check("rst.valid", 32'(out_valid), 32'd0);
        check("rst.imm", 32'(out_imm), 32'd0);
        check("rst.kind", 32'(out_kind), 32'd0);
        check("rst.pfx", 32'(out_prefixed), 32'd0);
        check("rst.in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back table, one instruction per cycle
        @(negedge clk);
        foreach (vecs[i]) begin
            drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].c);
            check($sformatf("vec%0d.in_ready", i), 32'(in_ready), 32'd1);
            @(negedge clk);
            expect_out($sformatf("vec%0d", i), vecs[i].imm, vecs[i].kind, 1'b0);
        end
        drive(1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
        @(negedge clk);
        check("drain.valid", 32'(out_valid), 32'd0);

        // Backpressure: second input stalls, first result held stable
        out_ready = 1'b0;
        drive(1'b1, 4'b1000, 4'h0, 4'h0, 4'h1);
        @(negedge clk);
        expect_out("bp.first", 16'h0001, 3'd1, 1'b0);
        check("bp.in_ready_low", 32'(in_ready), 32'd0);
        drive(1'b1, 4'b0101, 4'h0, 4'h1, 4'h2);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            expect_out($sformatf("bp.hold%0d", k), 16'h0001, 3'd1, 1'b0);
            check($sformatf("bp.hold%0d.in_ready", k), 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        #1;
        check("bp.in_ready_up", 32'(in_ready), 32'd1);
        @(negedge clk);
        expect_out("bp.second", 16'h0012, 3'd2, 1'b0);
        drive(1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
        @(negedge clk);
        check("bp.no_dup", 32'(out_valid), 32'd0);

        // Flush beats a simultaneous input
        drive(1'b1, 4'b1000, 4'h0, 4'h0, 4'h5);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        drive(1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
        check("flush.drop", 32'(out_valid), 32'd0);

        // Flush clears a held result
        out_ready = 1'b0;
        drive(1'b1, 4'b1000, 4'h0, 4'h0, 4'h6);
        @(negedge clk);
        expect_out("flush.held", 16'h0006, 3'd1, 1'b0);
        drive(1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush.held_clr", 32'(out_valid), 32'd0);
        out_ready = 1'b1;

`ifdef IMM_PREFIX_EN
        // PFX then ALU: prefix supplies upper 12 bits
        drive(1'b1, 4'b1111, 4'h1, 4'h2, 4'h3);
        @(negedge clk);
        check("pfx.bubble", 32'(out_valid), 32'd0);
        drive(1'b1, 4'b0101, 4'h0, 4'h9, 4'h4);
        @(negedge clk);
        expect_out("pfx.alu", 16'h1234, 3'd2, 1'b1);
        drive(1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
        @(negedge clk);

        // PFX then flush: prefix lost
        drive(1'b1, 4'b1111, 4'hF, 4'hF, 4'hF);
        @(negedge clk);
        drive(1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        drive(1'b1, 4'b0101, 4'h0, 4'h0, 4'h4);
        @(negedge clk);
        expect_out("pfx.flushed", 16'h0004, 3'd2, 1'b0);

        // PFX then UPPER: prefix discarded, then MEM is unprefixed
        drive(1'b1, 4'b1111, 4'h5, 4'h5, 4'h5);
        @(negedge clk);
        drive(1'b1, 4'b1101, 4'h0, 4'h1, 4'h2);
        @(negedge clk);
        expect_out("pfx.upper", 16'h1200, 3'd4, 1'b0);
        drive(1'b1, 4'b1000, 4'h0, 4'h0, 4'h2);
        @(negedge clk);
        expect_out("pfx.after_upper", 16'h0002, 3'd1, 1'b0);

        // PFX, PFX (overwrite), BRANCH
        drive(1'b1, 4'b1111, 4'h1, 4'h1, 4'h1);
        @(negedge clk);
        drive(1'b1, 4'b1111, 4'hA, 4'hB, 4'hC);
        @(negedge clk);
        drive(1'b1, 4'b1100, 4'h0, 4'h0, 4'hD);
        @(negedge clk);
        expect_out("pfx.overwrite", 16'hABCD, 3'd3, 1'b1);
        drive(1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
        @(negedge clk);
`endif

        // Asynchronous reset mid-stream
        drive(1'b1, 4'b1100, 4'h8, 4'h2, 4'h3);
        @(negedge clk);
        expect_out("arst.pre", 16'hF823, 3'd3, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.valid", 32'(out_valid), 32'd0);
        check("arst.imm", 32'(out_imm), 32'd0);
        check("arst.kind", 32'(out_kind), 32'd0);
        check("arst.pfx", 32'(out_prefixed), 32'd0);
        drive(1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 4'b0101, 4'h0, 4'h3, 4'h1);
        @(negedge clk);
        expect_out("arst.after", 16'h0031, 3'd2, 1'b0);
        drive(1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Pipelined, parametrised immediate generator for the ID stage. It replaces the combinational sign-extender: it decodes opcode plus three register-field nibbles into a DATA_W-bit immediate and registers the result behind a valid/ready handshake. An optional prefix mode lets one instruction supply the upper immediate bits for the next instruction.

## Interface
- DATA_W, 16, immediate output width; must satisfy DATA_W >= 3*FIELD_W
- FIELD_W, 4, width of each instruction field f1/f2/f3
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous pipeline flush from hazard/branch unit
- in_valid  in  1  instruction fields valid
- in_ready  out  1  block can accept this cycle
- opcode  in  4  instruction opcode
- f1, f2, f3  in  FIELD_W each  instruction fields, f1 most significant
- out_valid  out  1  result register holds a valid immediate
- out_ready  in  1  downstream (EX) accepts the result
- out_imm  out  DATA_W  generated immediate
- out_kind  out  3  0 NONE, 1 MEM, 2 ALU, 3 BRANCH, 4 UPPER
- out_prefixed  out  1  out_imm includes prefix bits

## Operation
- Decode, with SX(x) = sign-extend x to DATA_W:
  - 4'b1000 MEM: SX(f3)
  - 4'b0101 ALU: SX({f2,f3})
  - 4'b1100 BRANCH: SX({f1,f2,f3})
  - 4'b1101 UPPER: {f2,f3} in bits [DATA_W-1 : DATA_W-2*FIELD_W], zeros below
  - 4'b1111 PFX: see Configuration
  - any other opcode: imm 0, kind NONE
- Accept when in_valid && in_ready; in_ready = !out_valid || out_ready (combinational).
- An accepted instruction loads the output register. A held result (out_valid && !out_ready) keeps all outputs stable.
- Prefix state machine, two states, IDLE and ARMED:
  - IDLE -> ARMED on an accepted PFX; pfx_reg <= low DATA_W-FIELD_W bits of SX({f1,f2,f3}).
  - ARMED + accepted MEM/ALU/BRANCH: out_imm = {pfx_reg, f3}, out_prefixed=1, kind per opcode -> IDLE.
  - ARMED + accepted UPPER or NONE-kind instruction: prefix discarded, normal decode -> IDLE.
  - ARMED + accepted PFX: pfx_reg overwritten, stays ARMED.
- A PFX instruction produces no output (bubble): out_valid goes or stays 0 unless a held result exists.

## Timing
- Reset: out_valid=0, out_imm=0, out_kind=0, out_prefixed=0, state IDLE, pfx_reg=0. in_ready=1 after reset.
- Latency 1 cycle, accept-to-out_valid. Throughput 1 per cycle while out_ready=1.
- flush: next edge clears out_valid, state -> IDLE. Flush wins over a simultaneous in_valid; that input is dropped.
- Simultaneous out_ready and in_valid with out_valid=1: old result retires and new one loads on the same edge.
- rst_n low mid-operation clears immediately, independent of clk; a pending prefix is lost.

## Configuration
- IMM_PREFIX_EN defined: PFX opcode, ARMED state and pfx_reg present, as above.
- Not defined: 4'b1111 decodes as NONE (imm 0, out_valid=1, out_prefixed tied 0); no prefix state.

## Test plan
- Reset, then opcode 4'b1000 with f3=3, then f3=4'hA, out_ready=1 -> out_imm 16'h0003 kind 1, then 16'hFFFA, each one cycle after accept.
- Opcode 4'b0101 with f2=2, f3=3 -> 16'h0023 kind 2. Opcode 4'b1100 with f1=8, f2=2, f3=3 -> 16'hF823 kind 3.
- out_ready=0 with two back-to-back inputs -> in_ready falls, first result held stable. Raise out_ready -> second result follows, nothing lost or duplicated.
- IMM_PREFIX_EN: PFX with f1=1, f2=2, f3=3, then 4'b0101 with f3=4 -> no output for PFX, then 16'h1234, out_prefixed=1.
- PFX followed by flush, then 4'b0101 with f2=0, f3=4 -> 16'h0004, out_prefixed=0.
- Without macro: 4'b1111 -> out_valid=1, out_imm 0, kind 0. Assert rst_n mid-stream -> all outputs 0 asynchronously.
